// File: rtl/bcd_run_ctrl_pkg.sv
// Shared types and constants for the run/pause/clear BCD counter:
// state encoding, digit limits and the single-digit step helper.
package bcd_run_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } run_state_t;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [3:0] BCD_MIN    = 4'd0;
  localparam int         NUM_DIGITS = 4;
  localparam int         NUM_KEYS   = 2;
  localparam int         KEY_RUN    = 0;
  localparam int         KEY_CLR    = 1;
  localparam int         DBNC_CNT_W = 16;

  typedef struct packed {
    logic       carry;
    logic [3:0] digit;
  } digit_step_t;

  // One digit of the carry/borrow chain; carry out means this digit rolled over.
  function automatic digit_step_t bcd_digit_step(
    input logic [3:0] digit,
    input logic       en,
    input logic       down
  );
    digit_step_t res;
    res.carry = 1'b0;
    res.digit = digit;
    if (en) begin
      if (down) begin
        if (digit == BCD_MIN) begin
          res.digit = BCD_MAX;
          res.carry = 1'b1;
        end else begin
          res.digit = digit - 4'd1;
        end
      end else begin
        if (digit >= BCD_MAX) begin
          res.digit = BCD_MIN;
          res.carry = 1'b1;
        end else begin
          res.digit = digit + 4'd1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_run_ctrl_if.sv
// Front-panel keys, direction level and the BCD count bundle that feeds
// the display scan logic.
interface bcd_run_ctrl_if;
  logic        key_run;
  logic        key_clr;
  logic        dir;
  logic [15:0] num;
  logic        running;
  logic        wrap;

  modport master (
    output key_run,
    output key_clr,
    output dir,
    input  num,
    input  running,
    input  wrap
  );

  modport slave (
    input  key_run,
    input  key_clr,
    input  dir,
    output num,
    output running,
    output wrap
  );
endinterface

// File: rtl/bcd_run_ctrl_debounce.sv
// Two-flop synchronizer plus stability-counter debouncer for one raw key;
// emits a single-cycle pulse when the accepted level rises.
module key_debounce
  import bcd_run_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);

  localparam logic [DBNC_CNT_W-1:0] CNT_LAST = DBNC_CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]            sync_reg;
  logic [DBNC_CNT_W-1:0] cnt_reg;
  logic [DBNC_CNT_W-1:0] cnt_next;
  logic                  level_reg;
  logic                  level_next;
  logic                  press_reg;
  logic                  press_next;
  logic                  key_sync;

  assign key_sync = sync_reg[1];

  // Counter tracks how long the synchronized key has disagreed with the
  // accepted level; any agreement (a bounce back) starts it over.
  always_comb begin
    cnt_next   = cnt_reg;
    level_next = level_reg;
    press_next = 1'b0;
    if (key_sync == level_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_next   = '0;
      level_next = key_sync;
      press_next = key_sync;
    end else begin
      cnt_next = cnt_reg + DBNC_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg  <= '0;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], key};
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
      press_reg <= press_next;
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/bcd_run_ctrl.sv
// Operator-controlled 4-digit BCD up/down counter: debounced run/clear keys,
// run/pause/clear state machine, rate prescaler and the digit carry chain.
module bcd_run_ctrl
  import bcd_run_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_DIV        = 50000
) (
  input  logic          clk,
  input  logic          rst_n,
  bcd_run_ctrl_if.slave bus
);

  localparam int                  PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_press;
  logic                run_press;
  logic                clr_press;

  logic [1:0]          dir_sync_reg;
  logic                dir_down;

  run_state_t          state_reg;
  run_state_t          state_next;
  logic [PRESC_W-1:0]  presc_reg;
  logic [PRESC_W-1:0]  presc_next;
  logic [15:0]         num_reg;
  logic [15:0]         num_next;
  logic                wrap_reg;
  logic                wrap_next;
  logic                running_reg;
  logic                running_next;

  logic                step;
  logic [NUM_DIGITS:0] carry;
  logic [15:0]         chain_num;

  assign key_raw[KEY_RUN] = bus.key_run;
  assign key_raw[KEY_CLR] = bus.key_clr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key_raw[gi]),
        .press (key_press[gi])
      );
    end
  endgenerate

  assign run_press = key_press[KEY_RUN];
  assign clr_press = key_press[KEY_CLR];
  assign dir_down  = dir_sync_reg[1];

  // The chain always computes the "stepped" value; step only selects it.
  assign carry[0] = 1'b1;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      digit_step_t res;
      assign res = bcd_digit_step(num_reg[gi*4 +: 4], carry[gi], dir_down);
      assign chain_num[gi*4 +: 4] = res.digit;
      assign carry[gi+1]          = res.carry;
    end
  endgenerate

  // A clear press suppresses the step so a clear never reports a wrap.
  assign step = (state_reg == RUN) && (presc_reg == PRESC_LAST) && !clr_press;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (run_press) state_next = RUN;
      RUN:     if (run_press) state_next = PAUSE;
      PAUSE:   if (run_press) state_next = RUN;
      default: state_next = IDLE;
    endcase
    if (clr_press) begin
      state_next = IDLE;
    end
    running_next = (state_next == RUN);
  end

  always_comb begin
    presc_next = presc_reg;
    num_next   = num_reg;
    wrap_next  = 1'b0;
    case (state_reg)
      RUN: begin
        presc_next = (presc_reg == PRESC_LAST) ? '0 : presc_reg + PRESC_W'(1);
        if (step) begin
          num_next  = chain_num;
          wrap_next = carry[NUM_DIGITS];
        end
      end
      PAUSE: begin
      end
      default: begin
        presc_next = '0;
        num_next   = '0;
      end
    endcase
    if (clr_press) begin
      presc_next = '0;
      num_next   = '0;
      wrap_next  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      presc_reg    <= '0;
      num_reg      <= '0;
      wrap_reg     <= 1'b0;
      running_reg  <= 1'b0;
      dir_sync_reg <= '0;
    end else begin
      state_reg    <= state_next;
      presc_reg    <= presc_next;
      num_reg      <= num_next;
      wrap_reg     <= wrap_next;
      running_reg  <= running_next;
      dir_sync_reg <= {dir_sync_reg[0], bus.dir};
    end
  end

  assign bus.num     = num_reg;
  assign bus.running = running_reg;
  assign bus.wrap    = wrap_reg;

endmodule

// File: tb/tb_bcd_run_ctrl.sv
// Bench for bcd_run_ctrl: directed scenarios plus random key/dir traffic,
// every cycle compared against an integer-count reference model.
module tb_bcd_run_ctrl;

  localparam int D  = 4;
  localparam int TD = 3;
  localparam logic [31:0] WIN_MASK = (32'd1 << (D + 1)) - 32'd1;
  localparam int MODE_IDLE  = 0;
  localparam int MODE_RUN   = 1;
  localparam int MODE_PAUSE = 2;

  logic clk;
  logic rst_n;
  bcd_run_ctrl_if bus();

  bcd_run_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .TICK_DIV(TD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: count held as a plain integer 0..9999, key history as
  // sample windows (bit k = raw sample k edges ago, forced 0 around reset).
  logic [31:0] h_run, h_clr, h_dir;
  int m_mode, m_count, m_phase;
  bit m_wrap, lvl_run, lvl_clr, pend_run, pend_clr, model_valid;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r[15:12] = 4'(n / 1000);
    r[11:8]  = 4'((n / 100) % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[3:0]   = 4'(n % 10);
    return r;
  endfunction

  function automatic bit window_hit(input logic [31:0] h, input bit v);
    logic [31:0] w;
    w = (h >> 2) & WIN_MASK;
    return v ? (w == WIN_MASK) : (w == 32'd0);
  endfunction

  task automatic model_edge();
    bit pr, pc, ds;
    if (!rst_n) begin
      h_run = {h_run[30:0], 1'b0} & ~32'h3;
      h_clr = {h_clr[30:0], 1'b0} & ~32'h3;
      h_dir = {h_dir[30:0], 1'b0} & ~32'h3;
      m_mode = MODE_IDLE; m_count = 0; m_phase = 0; m_wrap = 0;
      lvl_run = 0; lvl_clr = 0; pend_run = 0; pend_clr = 0;
      model_valid = 1;
      return;
    end
    h_run = {h_run[30:0], bus.key_run};
    h_clr = {h_clr[30:0], bus.key_clr};
    h_dir = {h_dir[30:0], bus.dir};
    pr = pend_run; pc = pend_clr; ds = h_dir[2];
    m_wrap = 0;
    if (pc) begin
      m_mode = MODE_IDLE; m_count = 0; m_phase = 0;
    end else begin
      case (m_mode)
        MODE_IDLE: begin
          m_count = 0; m_phase = 0;
          if (pr) m_mode = MODE_RUN;
        end
        MODE_RUN: begin
          if (m_phase == TD - 1) begin
            m_phase = 0;
            if (!ds) begin
              if (m_count == 9999) begin m_count = 0; m_wrap = 1; end
              else m_count = m_count + 1;
            end else begin
              if (m_count == 0) begin m_count = 9999; m_wrap = 1; end
              else m_count = m_count - 1;
            end
          end else begin
            m_phase = m_phase + 1;
          end
          if (pr) m_mode = MODE_PAUSE;
        end
        default: if (pr) m_mode = MODE_RUN;
      endcase
    end
    pend_run = 0;
    if (window_hit(h_run, !lvl_run)) begin lvl_run = !lvl_run; pend_run = lvl_run; end
    pend_clr = 0;
    if (window_hit(h_clr, !lvl_clr)) begin lvl_clr = !lvl_clr; pend_clr = lvl_clr; end
    if (pend_run) $display("tb: cycle %0d run press accepted, count=%04d mode=%0d", cyc, m_count, m_mode);
    if (pend_clr) $display("tb: cycle %0d clear press accepted, count=%04d mode=%0d", cyc, m_count, m_mode);
  endtask

  task automatic compare_all();
    if (model_valid) begin
      check_val("num", bus.num, to_bcd(m_count));
      check_val("running", bus.running, m_mode == MODE_RUN);
      check_val("wrap", bus.wrap, m_wrap);
      for (int i = 0; i < 4; i++) check_val("digit_range", bus.num[i*4 +: 4] > 4'd9, 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    cyc++;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic toggle_run(input bit want);
    int n;
    bus.key_run = 1'b1;
    n = 0;
    while (bus.running !== want && n < 20) begin tick(); n++; end
    check_val("run_reach", bus.running, want);
    bus.key_run = 1'b0;
  endtask

  task automatic clear_all();
    bus.key_clr = 1'b1;
    tick_n(8);
    bus.key_clr = 1'b0;
    tick_n(8);
    check_val("clear_num", bus.num, 16'h0000);
  endtask

  task automatic wait_step(output int n);
    logic [15:0] prev;
    prev = bus.num;
    n = 0;
    while (bus.num === prev && n < 20) begin tick(); n++; end
    check_val("step_seen", bus.num !== prev, 1);
  endtask

  initial begin
    int n;
    logic [15:0] exp_hold;
    int held_phase;
    h_run = '0; h_clr = '0; h_dir = '0;
    m_mode = MODE_IDLE; m_count = 0; m_phase = 0; m_wrap = 0;
    lvl_run = 0; lvl_clr = 0; pend_run = 0; pend_clr = 0; model_valid = 0;
    rst_n = 1'b0; bus.key_run = 1'b1; bus.key_clr = 1'b0; bus.dir = 1'b0;

    $display("tb: reset with run key held");
    tick_n(5);
    check_val("rst_running", bus.running, 0);
    check_val("rst_num", bus.num, 16'h0000);
    check_val("rst_wrap", bus.wrap, 0);
    bus.key_run = 1'b0;
    tick();
    rst_n = 1'b1;
    tick_n(3);

    $display("tb: run press latency");
    bus.key_run = 1'b1;
    tick();
    n = 0;
    while (!bus.running && n < 30) begin tick(); n++; end
    check_val("run_latency", n, 7);
    bus.key_run = 1'b0;
    tick_n(10);

    $display("tb: bouncing run key");
    for (int i = 0; i < 5; i++) begin
      bus.key_run = 1'b1; tick_n(2);
      bus.key_run = 1'b0; tick_n(2);
    end
    check_val("bounce_no_event", bus.running, 1);
    bus.key_run = 1'b1;
    tick();
    n = 0;
    while (bus.running && n < 30) begin tick(); n++; end
    check_val("bounce_latency", n, 7);
    bus.key_run = 1'b0;
    tick_n(20);
    check_val("bounce_single_press", bus.running, 0);

    $display("tb: count up through 0998");
    clear_all();
    bus.dir = 1'b0;
    toggle_run(1);
    n = 0;
    while (bus.num !== 16'h0998 && n < 5000) begin tick(); n++; end
    check_val("reach_0998", bus.num, 16'h0998);
    wait_step(n);
    check_val("up_0999", bus.num, 16'h0999);
    wait_step(n);
    check_val("up_1000", bus.num, 16'h1000);
    bus.dir = 1'b1;
    wait_step(n);
    check_val("down_0999", bus.num, 16'h0999);

    $display("tb: down wrap from 0000");
    clear_all();
    toggle_run(1);
    wait_step(n);
    check_val("down_wrap_num", bus.num, 16'h9999);
    check_val("down_wrap_pulse", bus.wrap, 1);
    tick();
    check_val("wrap_one_cycle", bus.wrap, 0);
    wait_step(n);
    check_val("down_9998", bus.num, 16'h9998);
    bus.dir = 1'b0;
    wait_step(n);
    check_val("up_9999", bus.num, 16'h9999);
    wait_step(n);
    check_val("up_wrap_num", bus.num, 16'h0000);
    check_val("up_wrap_pulse", bus.wrap, 1);

    $display("tb: pause and resume");
    tick_n($urandom_range(0, 2));
    toggle_run(0);
    exp_hold = to_bcd(m_count);
    held_phase = m_phase;
    tick_n(50);
    check_val("pause_hold", bus.num, exp_hold);
    toggle_run(1);
    wait_step(n);
    check_val("resume_partial", n, TD - held_phase);

    $display("tb: run and clear together at 0042");
    clear_all();
    toggle_run(1);
    n = 0;
    while (bus.num !== 16'h0040 && n < 100) begin
      int k;
      wait_step(k);
      n++;
    end
    check_val("reach_0040", bus.num, 16'h0040);
    bus.key_run = 1'b1; bus.key_clr = 1'b1;
    tick_n(7);
    check_val("both_pre_num", bus.num, 16'h0042);
    check_val("both_pre_running", bus.running, 1);
    tick();
    check_val("both_num", bus.num, 16'h0000);
    check_val("both_running", bus.running, 0);
    check_val("both_wrap", bus.wrap, 0);
    bus.key_run = 1'b0; bus.key_clr = 1'b0;
    tick_n(10);

    $display("tb: reset mid-debounce");
    bus.key_run = 1'b1;
    tick_n(3);
    rst_n = 1'b0; bus.key_run = 1'b0;
    tick();
    rst_n = 1'b1;
    tick_n(20);
    check_val("rst_discard_running", bus.running, 0);
    check_val("rst_discard_num", bus.num, 16'h0000);

    $display("tb: random traffic");
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) bus.key_run = ~bus.key_run;
      if (bus.key_clr ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 59) == 0)) bus.key_clr = ~bus.key_clr;
      if ($urandom_range(0, 29) == 0) bus.dir = ~bus.dir;
      rst_n = ($urandom_range(0, 799) != 0);
      tick();
    end
    rst_n = 1'b1;
    tick_n(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_run_ctrl.md
# bcd_run_ctrl

Control and counting stage that feeds the 4-digit multiplexed 7-segment display path. It debounces two front-panel keys and runs a run/pause/clear state machine with a rate prescaler. It maintains a packed 4-digit BCD up/down count, 0000–9999, which is the 16-bit value consumed directly by the scan/digit-select logic. This replaces a free-running counter with an operator-controlled one.

## Interface
- DEBOUNCE_CYCLES, default 16: consecutive stable cycles required before a key level is accepted; range 2–65535.
- TICK_DIV, default 50000: clock cycles per count step while running; range 1–2^20.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- key_run  in  1  raw run/pause key, asynchronous, 1 = pressed.
- key_clr  in  1  raw clear key, asynchronous, 1 = pressed.
- dir  in  1  raw level: 0 = count up, 1 = count down. Synchronized only, not debounced.
- num  out  16  packed BCD count: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.
- running  out  1  1 while the state is RUN.
- wrap  out  1  one-cycle pulse on 9999→0000 (up) or 0000→9999 (down).

## Operation
- Every key input passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level changes only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts the debounce count.
  - A press event is a one-cycle pulse in the cycle the debounced level goes 0→1. Releases produce no event.
- dir passes through a 2-flop synchronizer only.
- State machine, 2-bit state:
  - IDLE: num = 0000, prescaler = 0. A run press moves to RUN.
  - RUN: prescaler counts. A run press moves to PAUSE.
  - PAUSE: num and prescaler hold. A run press moves to RUN.
  - A clear press in any state moves to IDLE, zeroes num and prescaler, and produces no wrap.
  - Run press and clear press in the same cycle: clear wins.
- Prescaler: counts 0..TICK_DIV-1 in RUN only and wraps to 0. A step fires in the cycle where the prescaler equals TICK_DIV-1. With TICK_DIV=1, a step fires every RUN cycle.
- Step, up (dir=0): increment the units digit. Each digit at 9 goes to 0 and carries to the next digit. 9999 → 0000 with wrap=1.
- Step, down (dir=1): decrement the units digit. Each digit at 0 goes to 9 and borrows from the next digit. 0000 → 9999 with wrap=1.
- Digits never hold values 10–15. Any such value is a design error and is covered by an assertion in the bench.
- A dir change takes effect on the next step. No step is lost or doubled.

## Timing
- Reset, when rst_n=0 at a rising edge:
  - state = IDLE; num = 16'h0000; running = 0; wrap = 0.
  - Prescaler, synchronizers, debounced levels and debounce counters all go to 0.
  - Reset mid-run or mid-debounce discards everything; no pending press survives.
- Key latency: a raw key held stable from edge 0 produces the press pulse in the cycle after edge 2+DEBOUNCE_CYCLES. State, running and num (on clear) update at the next edge, 3+DEBOUNCE_CYCLES.
- Step latency: the step cycle's edge updates num and wrap together. wrap is high for exactly that one cycle.
- First step after IDLE→RUN comes TICK_DIV cycles after entering RUN.
- Resume from PAUSE continues the held prescaler value, so the partial interval is preserved.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package bcd_run_pkg:
  - State encoding: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10. 2'b11 is illegal and recovers to IDLE.
  - Constants BCD_MAX=4'd9 and BCD_MIN=4'd0.
- Sub-module key_debounce, parameterized by DEBOUNCE_CYCLES and instantiated twice (run, clear).
  - Contains the synchronizer, stability counter, debounced level and press pulse.
- Prescaler, state machine and BCD digit chain live in bcd_run_ctrl.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, TICK_DIV=3.
- Reset with run key held → running=0, num=0000. A run press completed after release of rst_n moves running to 1 at 7 cycles after the key edge.
- Run key toggles 1/0 every 2 cycles for 20 cycles, then stays 1 → exactly one press event; no state change until 7 cycles after the final edge.
- RUN, dir=0, num preset to 0998 by stepping → next steps give 0999, then 1000. Preset to 9999 → next step gives 0000 with wrap=1 for 1 cycle.
- RUN, dir=1, from 0000 → 9999 with wrap=1, then 9998. From 1000 → 0999.
- RUN, then run press → PAUSE. Hold 50 cycles → num unchanged. Run press → RUN, and the first step arrives after only the remaining prescaler cycles.
- Run and clear pressed on the same cycle during RUN at num=0042 → IDLE, num=0000, running=0, no wrap. rst_n pulsed mid-debounce → press discarded.
